axi_rt_cfg_loader: RTL and testbench

- Register-bus master that sits directly upstream of the AXI RT unit's cfg port.
- Walks a table of (address, data) pairs and writes each pair to the RT unit config space (budgets, periods, region bounds, enables) after reset or on software request.
- Optionally reads each register back and compares it to the written value.
- Reports done/error status so boot firmware or a system controller can program all managers' RT settings without a CPU loop.

---
 rtl/axi_rt_cfg_loader_pkg.sv | 27 ++
 rtl/axi_rt_cfg_loader.sv | 207 ++++++++++++++++++++
 tb/tb_axi_rt_cfg_loader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rt_cfg_loader_pkg.sv
// Shared types and constants for the RT unit configuration loader.
// Holds the FSM encoding, the error codes and the index-width helper.
package axi_rt_cfg_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DONE,
        ERR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_BUS      = 2'd1,
        ERR_MISMATCH = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_e;

    localparam logic [3:0] CfgStrbFull = 4'hF;

    // Width needed to index num_idx entries; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
    endfunction

endpackage

// File: rtl/axi_rt_cfg_loader.sv
// Register-bus master that walks an (address, data) table into the RT unit
// config space, with optional readback compare and sticky done/error status.
module axi_rt_cfg_loader
    import axi_rt_cfg_loader_pkg::*;
#(
    parameter int unsigned NumEntries    = 16,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned TimeoutCycles = 256,
    parameter int unsigned IdxWidth      = idx_width(NumEntries),
    parameter int unsigned CntWidth      = $clog2(NumEntries + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic                         verify_i,
    input  logic [CntWidth-1:0]          num_entries_i,
    input  logic [NumEntries*AddrWidth-1:0] tbl_addr_i,
    input  logic [NumEntries*32-1:0]     tbl_data_i,
    output logic [AddrWidth-1:0]         cfg_addr_o,
    output logic [31:0]                  cfg_wdata_o,
    output logic [3:0]                   cfg_wstrb_o,
    output logic                         cfg_write_o,
    output logic                         cfg_valid_o,
    input  logic [31:0]                  cfg_rdata_i,
    input  logic                         cfg_error_i,
    input  logic                         cfg_ready_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         error_o,
    output logic [1:0]                   err_code_o,
    output logic [IdxWidth-1:0]          err_idx_o
);

    localparam int unsigned TmoWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 write;
        logic [31:0]          wdata;
        logic [3:0]           wstrb;
        logic                 valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

    state_e                state_q;
    logic [IdxWidth-1:0]   idx_q;
    logic [CntWidth-1:0]   n_q;
    logic                  verify_q;
    logic                  done_q;
    logic                  error_q;
    err_e                  err_code_q;
    logic [IdxWidth-1:0]   err_idx_q;
    logic [TmoWidth-1:0]   tmo_cnt_q;

    reg_req_t              req;
    reg_rsp_t              rsp;
    logic                  busy;
    logic                  hs;
    logic                  last;
    logic                  tmo_hit;
    logic                  tmo_clr;
    logic [CntWidth-1:0]   n_sat;

    logic [AddrWidth-1:0]  addr_tbl [NumEntries];
    logic [31:0]           data_tbl [NumEntries];

    for (genvar k = 0; k < NumEntries; k++) begin : g_tbl
        assign addr_tbl[k] = tbl_addr_i[k*AddrWidth +: AddrWidth];
        assign data_tbl[k] = tbl_data_i[k*32 +: 32];
    end

    assign busy    = (state_q == WRITE) || (state_q == READ);
    assign rsp     = '{rdata: cfg_rdata_i, error: cfg_error_i, ready: cfg_ready_i};
    assign hs      = req.valid && rsp.ready;
    assign last    = (CntWidth'(idx_q) == (n_q - CntWidth'(1)));
    assign n_sat   = (num_entries_i > CntWidth'(NumEntries)) ? CntWidth'(NumEntries)
                                                              : num_entries_i;
    assign tmo_hit = req.valid && !rsp.ready
                     && (tmo_cnt_q == TmoWidth'(TimeoutCycles - 1));
    // Every handshake starts a new request, so it restarts the wait budget too.
    assign tmo_clr = !busy || hs;

    always_comb begin
        req = '0;
        if (busy) begin
            req.addr  = addr_tbl[idx_q];
            req.wdata = data_tbl[idx_q];
            req.wstrb = CfgStrbFull;
            req.write = (state_q == WRITE);
            req.valid = 1'b1;
        end
    end

    // Saturating wait counter; it is held at its limit because the FSM
    // leaves the request state on the same edge the limit is reached.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else if (tmo_clr) begin
            tmo_cnt_q <= '0;
        end else if (req.valid && !rsp.ready
                     && (tmo_cnt_q != TmoWidth'(TimeoutCycles - 1))) begin
            tmo_cnt_q <= tmo_cnt_q + TmoWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            n_q        <= '0;
            verify_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            err_idx_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        err_code_q <= ERR_NONE;
                        err_idx_q  <= '0;
                        n_q        <= n_sat;
                        verify_q   <= verify_i;
                        idx_q      <= '0;
                        if (n_sat == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (hs) begin
                        if (rsp.error) begin
                            state_q    <= ERR;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_BUS;
                            err_idx_q  <= idx_q;
                        end else if (verify_q) begin
                            state_q <= READ;
                        end else if (last) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IdxWidth'(1);
                        end
                    end else if (tmo_hit) begin
                        state_q    <= ERR;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                        err_idx_q  <= idx_q;
                    end
                end
                READ: begin
                    if (hs) begin
                        if (rsp.error) begin
                            state_q    <= ERR;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_BUS;
                            err_idx_q  <= idx_q;
                        end else if (rsp.rdata != req.wdata) begin
                            state_q    <= ERR;
                            error_q    <= 1'b1;
                            err_code_q <= ERR_MISMATCH;
                            err_idx_q  <= idx_q;
                        end else if (last) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + IdxWidth'(1);
                            state_q <= WRITE;
                        end
                    end else if (tmo_hit) begin
                        state_q    <= ERR;
                        error_q    <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                        err_idx_q  <= idx_q;
                    end
                end
                DONE:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg_addr_o  = req.addr;
    assign cfg_wdata_o = req.wdata;
    assign cfg_wstrb_o = req.wstrb;
    assign cfg_write_o = req.write;
    assign cfg_valid_o = req.valid;
    assign busy_o      = busy;
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign err_code_o  = err_code_q;
    assign err_idx_o   = err_idx_q;

endmodule

// File: tb/tb_axi_rt_cfg_loader.sv
// Self-checking bench for axi_rt_cfg_loader: a reg-bus slave model feeds a
// request scoreboard while table vectors check the final status of each run.
module tb_axi_rt_cfg_loader;

    localparam int NE = 16;
    localparam int AW = 32;
    localparam int CW = $clog2(NE + 1);
    localparam int IW = 4;
    localparam int SW = 1 + AW + 32;

    logic               clk;
    logic               rst_n;
    logic               start_i;
    logic               verify_i;
    logic [CW-1:0]      num_entries_i;
    logic [NE*AW-1:0]   tbl_addr_i;
    logic [NE*32-1:0]   tbl_data_i;
    logic [AW-1:0]      cfg_addr_o;
    logic [31:0]        cfg_wdata_o;
    logic [3:0]         cfg_wstrb_o;
    logic               cfg_write_o;
    logic               cfg_valid_o;
    logic [31:0]        cfg_rdata_i;
    logic               cfg_error_i;
    logic               cfg_ready_i;
    logic               busy_o;
    logic               done_o;
    logic               error_o;
    logic [1:0]         err_code_o;
    logic [IW-1:0]      err_idx_o;

    axi_rt_cfg_loader #(
        .NumEntries    (NE),
        .AddrWidth     (AW),
        .TimeoutCycles (4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start_i),
        .verify_i      (verify_i),
        .num_entries_i (num_entries_i),
        .tbl_addr_i    (tbl_addr_i),
        .tbl_data_i    (tbl_data_i),
        .cfg_addr_o    (cfg_addr_o),
        .cfg_wdata_o   (cfg_wdata_o),
        .cfg_wstrb_o   (cfg_wstrb_o),
        .cfg_write_o   (cfg_write_o),
        .cfg_valid_o   (cfg_valid_o),
        .cfg_rdata_i   (cfg_rdata_i),
        .cfg_error_i   (cfg_error_i),
        .cfg_ready_i   (cfg_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o),
        .err_code_o    (err_code_o),
        .err_idx_o     (err_idx_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // scoreboard and slave model
    logic [SW-1:0] exp_q[$];
    logic [31:0]   mem [logic [31:0]];
    logic [31:0]   ent_addr [NE];
    logic [31:0]   ent_data [NE];
    bit            slv_ready_en = 1'b1;
    int            slv_err_wr   = -1;
    int            slv_bad_rd   = -1;
    int            wr_cnt       = 0;
    int            rd_cnt       = 0;
    int            vcyc         = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            cfg_ready_i = 1'b0;
            cfg_error_i = 1'b0;
            cfg_rdata_i = '0;
        end else begin
            cfg_ready_i = slv_ready_en;
            cfg_error_i = 1'b0;
            cfg_rdata_i = '0;
            if (cfg_valid_o) begin
                vcyc++;
                if (cfg_ready_i) begin
                    if (cfg_write_o) begin
                        if (wr_cnt == slv_err_wr) cfg_error_i = 1'b1;
                        mem[cfg_addr_o] = cfg_wdata_o;
                        wr_cnt++;
                    end else begin
                        cfg_rdata_i = mem.exists(cfg_addr_o) ? mem[cfg_addr_o] : 32'h0BAD_0000;
                        if (rd_cnt == slv_bad_rd) cfg_rdata_i = 32'hDEAD_BEEF;
                        rd_cnt++;
                    end
                    check("sb_wstrb", cfg_wstrb_o, 4'hF);
                    check("sb_req_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0)
                        check("sb_req", {cfg_write_o, cfg_addr_o, cfg_wdata_o}, exp_q.pop_front());
                end
            end
        end
    end

    // driver tasks
    task automatic fill_table(input int run_id);
        for (int k = 0; k < NE; k++) begin
            ent_addr[k] = 32'h4000_0000 + (run_id << 8) + (k << 2);
            ent_data[k] = (k == 1) ? 32'h0000_0010 : $urandom;
            tbl_addr_i[k*AW +: AW] = ent_addr[k];
            tbl_data_i[k*32 +: 32] = ent_data[k];
        end
    endtask

    task automatic prep_slave(input bit rdy, input int err_wr, input int bad_rd);
        slv_ready_en = rdy;
        slv_err_wr   = err_wr;
        slv_bad_rd   = bad_rd;
        wr_cnt       = 0;
        rd_cnt       = 0;
        vcyc         = 0;
        mem.delete();
        exp_q.delete();
    endtask

    task automatic pulse_start(input int n, input bit v);
        num_entries_i = n[CW-1:0];
        verify_i      = v;
        start_i       = 1'b1;
        @(negedge clk);
        start_i       = 1'b0;
        verify_i      = ~v;
        num_entries_i = 1;
    endtask

    typedef struct {
        int         n;
        bit         verify;
        bit         ready_en;
        int         err_wr;
        int         bad_rd;
        bit         extra_start;
        bit         exp_done;
        bit         exp_err;
        logic [1:0] exp_code;
        int         exp_idx;
        int         exp_vcyc;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input int id, input vec_t v);
        int eff;
        int waited;
        fill_table(id);
        prep_slave(v.ready_en, v.err_wr, v.bad_rd);
        eff = (v.n > NE) ? NE : v.n;
        if (v.ready_en) begin
            for (int k = 0; k < eff; k++) begin
                exp_q.push_back({1'b1, ent_addr[k], ent_data[k]});
                if (k == v.err_wr) break;
                if (v.verify) begin
                    exp_q.push_back({1'b0, ent_addr[k], ent_data[k]});
                    if (k == v.bad_rd) break;
                end
            end
        end
        pulse_start(v.n, v.verify);
        if (v.extra_start) begin
            @(negedge clk);
            start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
        end
        waited = 0;
        while (!((done_o || error_o) && !busy_o) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("v%0d_finished", id), waited < 300, 1);
        check($sformatf("v%0d_done", id), done_o, v.exp_done);
        check($sformatf("v%0d_error", id), error_o, v.exp_err);
        check($sformatf("v%0d_code", id), err_code_o, v.exp_code);
        if (v.exp_err) check($sformatf("v%0d_idx", id), err_idx_o, v.exp_idx[IW-1:0]);
        repeat (3) @(negedge clk);
        check($sformatf("v%0d_valid_cycles", id), vcyc, v.exp_vcyc);
        check($sformatf("v%0d_sb_drained", id), exp_q.size(), 0);
    endtask

    initial begin
        //           n  ver rdy errw badr xst done err code idx vcyc
        vecs[0] = '{ 2, 1, 1, -1, -1, 0, 1, 0, 2'd0, 0, 4 };
        vecs[1] = '{ 2, 1, 1, -1,  1, 0, 0, 1, 2'd2, 1, 4 };
        vecs[2] = '{ 1, 0, 0, -1, -1, 0, 0, 1, 2'd3, 0, 4 };
        vecs[3] = '{ 3, 1, 1, -1, -1, 0, 1, 0, 2'd0, 0, 6 };
        vecs[4] = '{ 4, 0, 1,  2, -1, 1, 0, 1, 2'd1, 2, 3 };
        vecs[5] = '{ 0, 0, 1, -1, -1, 0, 1, 0, 2'd0, 0, 0 };
        vecs[6] = '{20, 0, 1, -1, -1, 0, 1, 0, 2'd0, 0, 16 };
        vecs[7] = '{16, 1, 1, -1, -1, 0, 1, 0, 2'd0, 0, 32 };
        vecs[8] = '{ 2, 1, 1,  0, -1, 0, 0, 1, 2'd1, 0, 1 };
        vecs[9] = '{ 5, 0, 1, -1, -1, 0, 1, 0, 2'd0, 0, 5 };

        rst_n         = 1'b0;
        start_i       = 1'b0;
        verify_i      = 1'b0;
        num_entries_i = '0;
        tbl_addr_i    = '0;
        tbl_data_i    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_valid", cfg_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_error", error_o, 0);
        check("rst_code", err_code_o, 0);
        check("rst_idx", err_idx_o, 0);
        check("rst_addr", cfg_addr_o, 0);

        // back-to-back writes land on cycles 1..3, done visible on cycle 4
        fill_table(100);
        prep_slave(1'b1, -1, -1);
        for (int k = 0; k < 3; k++) exp_q.push_back({1'b1, ent_addr[k], ent_data[k]});
        pulse_start(3, 1'b0);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("t1_valid_c%0d", c + 1), cfg_valid_o, 1);
            check($sformatf("t1_addr_c%0d", c + 1), cfg_addr_o, ent_addr[c]);
            check($sformatf("t1_busy_c%0d", c + 1), busy_o, 1);
            @(negedge clk);
        end
        check("t1_done", done_o, 1);
        check("t1_busy_end", busy_o, 0);
        check("t1_valid_end", cfg_valid_o, 0);
        check("t1_code", err_code_o, 0);
        repeat (2) @(negedge clk);
        check("t1_sb_drained", exp_q.size(), 0);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // reset while a write is outstanding
        fill_table(200);
        prep_slave(1'b0, -1, -1);
        pulse_start(5, 1'b1);
        @(negedge clk);
        check("rst_mid_valid_before", cfg_valid_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", cfg_valid_o, 0);
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_addr", cfg_addr_o, 0);
        check("rst_mid_wdata", cfg_wdata_o, 0);
        check("rst_mid_write", cfg_write_o, 0);
        check("rst_mid_status", {done_o, error_o, err_code_o, err_idx_o}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        slv_ready_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_stays_idle", cfg_valid_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
